// File: rtl/nand_exer_pkg.sv
// ---------------------------------------------------------------------------
// nand_exer_pkg
// Shared types and helpers for the NAND cell exerciser.
//   exer_state_t : exerciser FSM states (IDLE, DRIVE, SETTLE, SAMPLE, DONE)
//   VEC_W        : width of the vector index; one bit per NAND operand
//   nand_exp()   : ideal NAND response used as the expected cell output
// ---------------------------------------------------------------------------
package nand_exer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } exer_state_t;

  localparam int VEC_W = 2;

  // Ideal 2-input NAND, the reference the cell under test is judged against.
  function automatic logic nand_exp(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/nand_exerciser_if.sv
// ---------------------------------------------------------------------------
// nand_exerciser_if
// Bundles the run handshake, the cell drive/response pair and the result
// outputs of the NAND exerciser.
//   master : exerciser side (drives a/b and results, receives start and w)
//   slave  : environment side (drives start and w, observes everything else)
// Parameter ERR_W must match the ERR_W of the nand_exerciser it connects to.
// Optional macro NAND_EXER_FAIL_CAPTURE_EN adds first_fail_vld/first_fail_vec.
// ---------------------------------------------------------------------------
interface nand_exerciser_if #(
  parameter int ERR_W = 8
);
  import nand_exer_pkg::*;

  logic             start;
  logic             a;
  logic             b;
  logic             w;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [VEC_W-1:0] vec_idx;

`ifdef NAND_EXER_FAIL_CAPTURE_EN
  logic             first_fail_vld;
  logic [VEC_W-1:0] first_fail_vec;

  modport master (
    input  start, w,
    output a, b, busy, done, pass, err_count, vec_idx,
    output first_fail_vld, first_fail_vec
  );

  modport slave (
    output start, w,
    input  a, b, busy, done, pass, err_count, vec_idx,
    input  first_fail_vld, first_fail_vec
  );
`else
  modport master (
    input  start, w,
    output a, b, busy, done, pass, err_count, vec_idx
  );

  modport slave (
    output start, w,
    input  a, b, busy, done, pass, err_count, vec_idx
  );
`endif

endinterface

// File: rtl/nand_exer_settle_timer.sv
// ---------------------------------------------------------------------------
// nand_exer_settle_timer
// Counts the settle window between driving the cell operands and sampling
// the cell output. The count runs 0..SETTLE_CYCLES-1 and parks on the last
// value, where terminal is raised.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return the count to 0 (takes priority over enable)
//   enable     : advance the count by one per cycle
//   terminal   : count has reached SETTLE_CYCLES-1
// ---------------------------------------------------------------------------
module nand_exer_settle_timer #(
  parameter  int SETTLE_CYCLES = 4,
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  // With SETTLE_CYCLES=1 the count sits at 0, so terminal is already high on
  // the first settle cycle and the window is exactly one cycle long.
  assign terminal = (count == CNT_W'(SETTLE_CYCLES - 1));

  // Parking on the terminal value keeps the counter from wrapping if the
  // controller lingers in its settle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nand_exerciser.sv
// ---------------------------------------------------------------------------
// nand_exerciser
// Stimulus and response checker for a 2-input NAND cell. Each run sweeps the
// operand pair through 00, 01, 10, 11 (LOOPS times), waits SETTLE_CYCLES after
// each drive, samples the cell output w and counts mismatches against the
// ideal NAND in a saturating error counter.
// Parameters:
//   SETTLE_CYCLES (>=1) : cycles between driving a/b and sampling w
//   LOOPS         (>=1) : full 4-vector sweeps per run
//   ERR_W               : width of err_count (must equal the interface ERR_W)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : nand_exerciser_if master modport
//                start (level-sampled run request), w (cell output) in;
//                a/b (registered operands), busy, done, pass, err_count,
//                vec_idx out
// Optional macro NAND_EXER_FAIL_CAPTURE_EN: adds first_fail_vld and
// first_fail_vec, recording the vector of the first mismatch in a run.
// ---------------------------------------------------------------------------
module nand_exerciser
  import nand_exer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  nand_exerciser_if.master bus
);

  // Sized to hold 0..LOOPS so the increment on the final wrap cannot overflow.
  localparam int LOOP_W = (LOOPS > 0) ? $clog2(LOOPS + 1) : 1;

  exer_state_t       state;
  logic [LOOP_W-1:0] loop_cnt;
  logic              settle_done;
  logic              expected;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;

  nand_exer_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == DRIVE),
    .enable  (state == SETTLE),
    .terminal(settle_done)
  );

  // Compare against the operands actually presented to the cell. The
  // case-inequality makes an X or Z on w count as a mismatch in simulation.
  always_comb begin
    expected = nand_exp(bus.a, bus.b);
    mismatch = (bus.w !== expected);
    err_next = bus.err_count;
    if (mismatch && (bus.err_count != '1)) begin
      err_next = bus.err_count + ERR_W'(1);
    end
  end

  // Run controller. All outputs are registered here, so busy/done/pass and
  // the operands change only on clock edges (or asynchronously on reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.a         <= 1'b0;
      bus.b         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= '0;
      bus.vec_idx   <= '0;
      loop_cnt      <= '0;
`ifdef NAND_EXER_FAIL_CAPTURE_EN
      bus.first_fail_vld <= 1'b0;
      bus.first_fail_vec <= '0;
`endif
    end else begin
      case (state)
        // start is only looked at here, so a request during a run is dropped.
        IDLE, DONE: begin
          if (bus.start) begin
            state         <= DRIVE;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
            bus.vec_idx   <= '0;
            loop_cnt      <= '0;
`ifdef NAND_EXER_FAIL_CAPTURE_EN
            bus.first_fail_vld <= 1'b0;
            bus.first_fail_vec <= '0;
`endif
          end
        end

        DRIVE: begin
          bus.a <= bus.vec_idx[1];
          bus.b <= bus.vec_idx[0];
          state <= SETTLE;
        end

        SETTLE: begin
          if (settle_done) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          bus.err_count <= err_next;
`ifdef NAND_EXER_FAIL_CAPTURE_EN
          if (mismatch && !bus.first_fail_vld) begin
            bus.first_fail_vld <= 1'b1;
            bus.first_fail_vec <= bus.vec_idx;
          end
`endif
          // vec_idx wraps 3->0 naturally in its two bits.
          bus.vec_idx <= bus.vec_idx + VEC_W'(1);
          state       <= DRIVE;
          if (bus.vec_idx == '1) begin
            loop_cnt <= loop_cnt + LOOP_W'(1);
            if (loop_cnt == LOOP_W'(LOOPS - 1)) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (err_next == '0);
              bus.a    <= 1'b0;
              bus.b    <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_exerciser.sv
// ---------------------------------------------------------------------------
// tb_nand_exerciser
// Three exerciser instances with different settle/loop/counter widths, each
// connected to an emulated NAND cell whose per-vector fault mask (flip) is
// set by the bench. Expected results come from counting faulty vectors.
// ---------------------------------------------------------------------------
module tb_nand_exerciser;

  localparam int N = 3;
  localparam int SET_C  [N] = '{4, 4, 1};
  localparam int LOOP_C [N] = '{1, 2, 2};
  localparam int ERRW_C [N] = '{8, 8, 2};

  logic clk;
  logic rst_n;
  logic [N-1:0]      start_v;
  logic [N-1:0][3:0] flip_v;

  logic [N-1:0]      busy_v, done_v, pass_v, a_v, b_v;
  logic [N-1:0][7:0] err_v;
  logic [N-1:0][1:0] vec_v;
`ifdef NAND_EXER_FAIL_CAPTURE_EN
  logic [N-1:0]      ffvld_v;
  logic [N-1:0][1:0] ffvec_v;
`endif

  int total = 0;
  int bad   = 0;

  nand_exerciser_if #(.ERR_W(ERRW_C[0])) if0 ();
  nand_exerciser_if #(.ERR_W(ERRW_C[1])) if1 ();
  nand_exerciser_if #(.ERR_W(ERRW_C[2])) if2 ();

  nand_exerciser #(.SETTLE_CYCLES(SET_C[0]), .LOOPS(LOOP_C[0]), .ERR_W(ERRW_C[0]))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  nand_exerciser #(.SETTLE_CYCLES(SET_C[1]), .LOOPS(LOOP_C[1]), .ERR_W(ERRW_C[1]))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  nand_exerciser #(.SETTLE_CYCLES(SET_C[2]), .LOOPS(LOOP_C[2]), .ERR_W(ERRW_C[2]))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Emulated cell: ideal NAND, inverted on vectors whose flip bit is set.
  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.w = ~(if0.a & if0.b) ^ flip_v[0][{if0.a, if0.b}];
  assign if1.w = ~(if1.a & if1.b) ^ flip_v[1][{if1.a, if1.b}];
  assign if2.w = ~(if2.a & if2.b) ^ flip_v[2][{if2.a, if2.b}];

  assign busy_v = {if2.busy, if1.busy, if0.busy};
  assign done_v = {if2.done, if1.done, if0.done};
  assign pass_v = {if2.pass, if1.pass, if0.pass};
  assign a_v    = {if2.a, if1.a, if0.a};
  assign b_v    = {if2.b, if1.b, if0.b};
  assign err_v  = {8'(if2.err_count), 8'(if1.err_count), 8'(if0.err_count)};
  assign vec_v  = {if2.vec_idx, if1.vec_idx, if0.vec_idx};
`ifdef NAND_EXER_FAIL_CAPTURE_EN
  assign ffvld_v = {if2.first_fail_vld, if1.first_fail_vld, if0.first_fail_vld};
  assign ffvec_v = {if2.first_fail_vec, if1.first_fail_vec, if0.first_fail_vec};
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every faulty vector mismatches once per loop.
  function automatic int model_err(input logic [3:0] flip, input int idx);
    int raw;
    int cap;
    raw = $countones(flip) * LOOP_C[idx];
    cap = (1 << ERRW_C[idx]) - 1;
    return (raw > cap) ? cap : raw;
  endfunction

  function automatic int model_first(input logic [3:0] flip);
    for (int i = 0; i < 4; i++) if (flip[i]) return i;
    return 0;
  endfunction

  function automatic int run_cycles(input int idx);
    return 4 * LOOP_C[idx] * (SET_C[idx] + 2);
  endfunction

  // Pulse start for one edge; returns #1 after the accept edge.
  task automatic start_run(input int idx, input logic [3:0] flip);
    flip_v[idx]  = flip;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
  endtask

  // Edges until done is seen, or -1 if the bound expires.
  task automatic wait_done(input int idx, output int cycles);
    cycles = 0;
    while (!done_v[idx] && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!done_v[idx]) cycles = -1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      total++;
      if ({busy_v[i], done_v[i], pass_v[i], a_v[i], b_v[i], err_v[i], vec_v[i]} !== 15'd0) begin
        bad++;
        $display("[TB] FAIL reset_state[%0d]: got busy=%b done=%b pass=%b a=%b b=%b err=%0d vec=%0d want all 0",
                 i, busy_v[i], done_v[i], pass_v[i], a_v[i], b_v[i], err_v[i], vec_v[i]);
      end
`ifdef NAND_EXER_FAIL_CAPTURE_EN
      total++;
      if ({ffvld_v[i], ffvec_v[i]} !== 3'd0) begin
        bad++;
        $display("[TB] FAIL reset_ff[%0d]: got vld=%b vec=%0d want 0", i, ffvld_v[i], ffvec_v[i]);
      end
`endif
    end
  endtask

  task automatic test_ideal_sweep();
    int cyc;
    int k;
    start_run(0, 4'b0000);
    total++;
    if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL accept: got busy=%b done=%b want busy=1 done=0", busy_v[0], done_v[0]);
    end
    cyc = 0;
    for (int c = 1; c <= run_cycles(0); c++) begin
      @(posedge clk); #1;
      cyc = c;
      if (c % (SET_C[0] + 2) == 1) begin
        k = c / (SET_C[0] + 2);
        total++;
        if ({a_v[0], b_v[0]} !== 2'(k) || vec_v[0] !== 2'(k)) begin
          bad++;
          $display("[TB] FAIL sweep_vec: got ab=%b%b vec=%0d want %0d", a_v[0], b_v[0], vec_v[0], k);
        end
      end
      if (c == run_cycles(0) - 1) begin
        total++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
          bad++;
          $display("[TB] FAIL early_done: got done=%b busy=%b want done=0 busy=1", done_v[0], busy_v[0]);
        end
      end
    end
    total++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || pass_v[0] !== 1'b1 || err_v[0] !== 8'd0
        || a_v[0] !== 1'b0 || b_v[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ideal_done at cycle %0d: got done=%b busy=%b pass=%b err=%0d ab=%b%b want 1 0 1 0 00",
               cyc, done_v[0], busy_v[0], pass_v[0], err_v[0], a_v[0], b_v[0]);
    end
  endtask

  task automatic test_patterns(input bit randomized, input int iters);
    int idx;
    int cyc;
    logic [3:0] flip;
    int fix_idx [5] = '{1, 0, 2, 2, 1};
    logic [3:0] fix_flip [5] = '{4'b1000, 4'b0111, 4'b0111, 4'b0000, 4'b0101};
    for (int it = 0; it < iters; it++) begin
      if (randomized) begin
        idx  = it % N;
        flip = 4'($urandom_range(0, 15));
      end else begin
        idx  = fix_idx[it];
        flip = fix_flip[it];
      end
      start_run(idx, flip);
      wait_done(idx, cyc);
      total++;
      if (cyc !== run_cycles(idx)) begin
        bad++;
        $display("[TB] FAIL done_latency[%0d flip=%b]: got %0d want %0d", idx, flip, cyc, run_cycles(idx));
      end
      total++;
      if (err_v[idx] !== 8'(model_err(flip, idx))) begin
        bad++;
        $display("[TB] FAIL err_count[%0d flip=%b]: got %0d want %0d", idx, flip, err_v[idx], model_err(flip, idx));
      end
      total++;
      if (pass_v[idx] !== (flip == 4'b0000) || busy_v[idx] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL pass[%0d flip=%b]: got pass=%b busy=%b want pass=%b busy=0",
                 idx, flip, pass_v[idx], busy_v[idx], (flip == 4'b0000));
      end
`ifdef NAND_EXER_FAIL_CAPTURE_EN
      total++;
      if (ffvld_v[idx] !== (flip != 4'b0000)
          || (flip != 4'b0000 && ffvec_v[idx] !== 2'(model_first(flip)))) begin
        bad++;
        $display("[TB] FAIL first_fail[%0d flip=%b]: got vld=%b vec=%0d want vld=%b vec=%0d",
                 idx, flip, ffvld_v[idx], ffvec_v[idx], (flip != 4'b0000), model_first(flip));
      end
`endif
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    start_run(0, 4'b0111);
    // Vector 2 is driven on edge 13; edge 14 is inside its settle window.
    repeat (2 * (SET_C[0] + 2) + 2) @(posedge clk);
    #1;
    total++;
    if (err_v[0] !== 8'd2 || a_v[0] !== 1'b1 || b_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset: got err=%0d ab=%b%b busy=%b want err=2 ab=10 busy=1",
               err_v[0], a_v[0], b_v[0], busy_v[0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy_v[0], done_v[0], pass_v[0], a_v[0], b_v[0], err_v[0], vec_v[0]} !== 15'd0) begin
      bad++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b a=%b b=%b err=%0d vec=%0d want all 0",
               busy_v[0], done_v[0], a_v[0], b_v[0], err_v[0], vec_v[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_run(0, 4'b0000);
    wait_done(0, cyc);
    total++;
    if (cyc !== run_cycles(0) || err_v[0] !== 8'd0 || pass_v[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL restart: got cycles=%0d err=%0d pass=%b want %0d 0 1",
               cyc, err_v[0], pass_v[0], run_cycles(0));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    flip_v[0]  = 4'b0000;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    wait_done(0, cyc);
    total++;
    if (cyc !== run_cycles(0)) begin
      bad++;
      $display("[TB] FAIL held_start_latency: got %0d want %0d", cyc, run_cycles(0));
    end
    @(posedge clk); #1;
    total++;
    if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rerun: got busy=%b done=%b want busy=1 done=0", busy_v[0], done_v[0]);
    end
    start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, cyc);
    total++;
    if (cyc !== run_cycles(0) - 6) begin
      bad++;
      $display("[TB] FAIL busy_start_ignored: got %0d want %0d", cyc, run_cycles(0) - 6);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL not_queued: got done=%b busy=%b want done=1 busy=0", done_v[0], busy_v[0]);
    end
  endtask

  initial begin
    start_v = '0;
    flip_v  = '0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_ideal_sweep();
    test_patterns(1'b0, 5);
    test_reset_mid_run();
    test_back_to_back();
    test_patterns(1'b1, 9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
